// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - writeback port arbiter bus interface
//
// Purpose: bundles the pipeline writeback slot, the long-latency return
// channel and the register-file write port of wb_port_arbiter.
// Signals:
//   pipe_valid/pipe_regw/pipe_rd/pipe_result : in-order writeback slot
//   lu_valid/lu_ready/lu_rd/lu_data          : long-latency result handshake
//   rf_we/rf_a3/rf_wd                        : register-file write port
//   stall_req                                : writeback bubble request
//   buf_count                                : long-latency FIFO occupancy
// Modports: slave = arbiter side, master = pipeline/unit/register-file side.
interface wb_port_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              pipe_valid;
  logic              pipe_regw;
  logic [REG_AW-1:0] pipe_rd;
  logic [XLEN-1:0]   pipe_result;
  logic              lu_valid;
  logic              lu_ready;
  logic [REG_AW-1:0] lu_rd;
  logic [XLEN-1:0]   lu_data;
  logic              rf_we;
  logic [REG_AW-1:0] rf_a3;
  logic [XLEN-1:0]   rf_wd;
  logic              stall_req;
  logic [CNT_W-1:0]  buf_count;

  modport slave (
    input  pipe_valid, pipe_regw, pipe_rd, pipe_result,
    input  lu_valid, lu_rd, lu_data,
    output lu_ready, rf_we, rf_a3, rf_wd, stall_req, buf_count
  );

  modport master (
    output pipe_valid, pipe_regw, pipe_rd, pipe_result,
    output lu_valid, lu_rd, lu_data,
    input  lu_ready, rf_we, rf_a3, rf_wd, stall_req, buf_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter with long-latency FIFO
//
// Purpose: the pipeline writeback always owns the write port; long-latency
// results wait in a small FIFO and drain into free cycles. A head that has
// waited STARVE_LIMIT cycles raises stall_req. Queued writes overtaken by a
// younger pipeline write to the same register are killed and discarded.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : wb_port_arbiter_if.slave (writeback slot, long-latency channel,
//           register-file write port, stall_req, buf_count)
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_port_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  logic [REG_AW-1:0] r_rd   [DEPTH];
  logic [XLEN-1:0]   r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [DEPTH-1:0]  r_kill;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W-1:0]  r_wptr;
  logic [CNT_W-1:0]  r_count;
  logic [SW-1:0]     r_starve;
  logic              r_stall;

  logic w_empty;
  logic w_full;
  logic w_pipe_win;
  logic w_head_kill;
  logic w_pop;
  logic w_drain;
  logic w_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(DEPTH));
  // Gated by rst_n so the port is quiet while reset is held, not just after.
  assign w_pipe_win  = rst_n & bus.pipe_valid & bus.pipe_regw & (bus.pipe_rd != '0);
  assign w_head_kill = r_kill[r_rptr];
  // A killed head leaves even when the pipeline owns the port; it never writes.
  assign w_pop       = !w_empty & (w_head_kill | !w_pipe_win);
  assign w_drain     = w_pop & !w_head_kill;
  // Writes to x0 complete the handshake but are dropped.
  assign w_push      = bus.lu_valid & !w_full & (bus.lu_rd != '0);

  assign bus.lu_ready  = !w_full;
  assign bus.stall_req = r_stall;
  assign bus.buf_count = r_count;

  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_a3 = '0;
    bus.rf_wd = '0;
    if (w_pipe_win) begin
      bus.rf_we = 1'b1;
      bus.rf_a3 = bus.pipe_rd;
      bus.rf_wd = bus.pipe_result;
    end else if (w_drain) begin
      bus.rf_we = 1'b1;
      bus.rf_a3 = r_rd[r_rptr];
      bus.rf_wd = r_data[r_rptr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= bus.lu_rd;
      r_data[r_wptr] <= bus.lu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld    <= '0;
      r_kill   <= '0;
      r_rptr   <= '0;
      r_wptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      // Only resident entries are compared; the slot being filled this cycle
      // is not valid yet, so a same-cycle arrival escapes the kill.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_pipe_win && r_vld[i] && (r_rd[i] == bus.pipe_rd)) begin
          r_kill[i] <= 1'b1;
        end
      end
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= ptr_inc(r_rptr);
      end
      if (w_push) begin
        r_vld[r_wptr]  <= 1'b1;
        r_kill[r_wptr] <= 1'b0;
        r_wptr         <= ptr_inc(r_wptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      // A non-empty FIFO that does not pop always has a live head.
      if (w_empty || w_pop) begin
        r_starve <= '0;
      end else if (r_starve != SW'(STARVE_LIMIT)) begin
        r_starve <= r_starve + 1'b1;
      end
      r_stall <= !w_empty && !w_pop && (r_starve == SW'(STARVE_LIMIT));
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  wb_port_arbiter_if #(.XLEN(32), .REG_AW(5), .DEPTH(2)) bus ();

  wb_port_arbiter #(.XLEN(32), .REG_AW(5), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic v, input logic regw, input logic [4:0] rd, input logic [31:0] d);
    bus.pipe_valid  = v;
    bus.pipe_regw   = regw;
    bus.pipe_rd     = rd;
    bus.pipe_result = d;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.lu_valid = v;
    bus.lu_rd    = rd;
    bus.lu_data  = d;
  endtask

  task automatic do_reset;
    set_pipe(0, 0, 0, 0);
    set_lu(0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    set_pipe(0, 0, 0, 0);
    set_lu(0, 0, 0);
    rst_n = 1'b0;
    #2;
    n_vec++; if (bus.lu_ready !== 1'b1) begin n_err++; $display("FAIL reset_lu_ready got %b want 1", bus.lu_ready); end
    n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got %b want 0", bus.rf_we); end
    n_vec++; if (bus.rf_a3 !== 5'd0) begin n_err++; $display("FAIL reset_rf_a3 got %0d want 0", bus.rf_a3); end
    n_vec++; if (bus.rf_wd !== 32'h0) begin n_err++; $display("FAIL reset_rf_wd got %h want 0", bus.rf_wd); end
    n_vec++; if (bus.stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", bus.stall_req); end
    n_vec++; if (bus.buf_count !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.buf_count); end
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_pipe_gating;
    do_reset();
    set_pipe(1, 0, 5'd12, 32'h1234);
    #1;
    n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL gate_noregw_we got %b want 0", bus.rf_we); end
    set_pipe(1, 1, 5'd0, 32'h1234);
    #1;
    n_vec++; if ({bus.rf_we, bus.rf_a3, bus.rf_wd} !== {1'b0, 5'd0, 32'h0}) begin n_err++; $display("FAIL gate_x0 got we=%b a3=%0d wd=%h want 0/0/0", bus.rf_we, bus.rf_a3, bus.rf_wd); end
    set_pipe(1, 1, 5'd12, 32'h1234);
    #1;
    n_vec++; if ({bus.rf_we, bus.rf_a3, bus.rf_wd} !== {1'b1, 5'd12, 32'h1234}) begin n_err++; $display("FAIL gate_win got we=%b a3=%0d wd=%h want 1/12/1234", bus.rf_we, bus.rf_a3, bus.rf_wd); end
  endtask

  task automatic test_idle_drain;
    do_reset();
    set_lu(1, 5'd5, 32'hDEAD);
    #1;
    n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL drain_no_bypass got %b want 0", bus.rf_we); end
    tick();
    set_lu(0, 0, 0);
    #1;
    n_vec++; if ({bus.rf_we, bus.rf_a3, bus.rf_wd} !== {1'b1, 5'd5, 32'hDEAD}) begin n_err++; $display("FAIL drain_write got we=%b a3=%0d wd=%h want 1/5/dead", bus.rf_we, bus.rf_a3, bus.rf_wd); end
    n_vec++; if (bus.buf_count !== 2'd1) begin n_err++; $display("FAIL drain_count1 got %0d want 1", bus.buf_count); end
    tick();
    n_vec++; if (bus.buf_count !== 2'd0 || bus.rf_we !== 1'b0) begin n_err++; $display("FAIL drain_empty got cnt=%0d we=%b want 0/0", bus.buf_count, bus.rf_we); end
  endtask

  task automatic test_priority;
    do_reset();
    set_lu(1, 5'd7, 32'h77);
    tick();
    set_lu(0, 0, 0);
    set_pipe(1, 1, 5'd3, 32'h11);
    #1;
    n_vec++; if ({bus.rf_we, bus.rf_a3, bus.rf_wd} !== {1'b1, 5'd3, 32'h11}) begin n_err++; $display("FAIL prio_pipe got we=%b a3=%0d wd=%h want 1/3/11", bus.rf_we, bus.rf_a3, bus.rf_wd); end
    tick();
    set_pipe(0, 0, 0, 0);
    #1;
    n_vec++; if (bus.buf_count !== 2'd1) begin n_err++; $display("FAIL prio_held got %0d want 1", bus.buf_count); end
    n_vec++; if ({bus.rf_we, bus.rf_a3, bus.rf_wd} !== {1'b1, 5'd7, 32'h77}) begin n_err++; $display("FAIL prio_late got we=%b a3=%0d wd=%h want 1/7/77", bus.rf_we, bus.rf_a3, bus.rf_wd); end
    tick();
    n_vec++; if (bus.buf_count !== 2'd0) begin n_err++; $display("FAIL prio_empty got %0d want 0", bus.buf_count); end
  endtask

  task automatic test_starvation;
    do_reset();
    set_pipe(1, 1, 5'd10, 32'hA0);
    set_lu(1, 5'd9, 32'h99);
    tick();
    set_lu(0, 0, 0);
    n_vec++; if (bus.stall_req !== 1'b0) begin n_err++; $display("FAIL starve_c0 got %b want 0", bus.stall_req); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_vec++; if (bus.stall_req !== (k == 5)) begin n_err++; $display("FAIL starve_cycle%0d got %b want %b", k, bus.stall_req, (k == 5)); end
    end
    n_vec++; if (bus.rf_a3 !== 5'd10) begin n_err++; $display("FAIL starve_prio got %0d want 10", bus.rf_a3); end
    set_pipe(0, 0, 0, 0);
    #1;
    n_vec++; if ({bus.rf_we, bus.rf_a3, bus.rf_wd} !== {1'b1, 5'd9, 32'h99}) begin n_err++; $display("FAIL starve_drain got we=%b a3=%0d wd=%h want 1/9/99", bus.rf_we, bus.rf_a3, bus.rf_wd); end
    tick();
    n_vec++; if (bus.stall_req !== 1'b0 || bus.buf_count !== 2'd0) begin n_err++; $display("FAIL starve_release got stall=%b cnt=%0d want 0/0", bus.stall_req, bus.buf_count); end
  endtask

  task automatic test_kill;
    do_reset();
    set_pipe(1, 1, 5'd6, 32'h66);
    set_lu(1, 5'd4, 32'hAA);
    tick();
    set_lu(0, 0, 0);
    set_pipe(1, 1, 5'd4, 32'hBB);
    #1;
    n_vec++; if ({bus.rf_we, bus.rf_a3, bus.rf_wd} !== {1'b1, 5'd4, 32'hBB}) begin n_err++; $display("FAIL kill_young got we=%b a3=%0d wd=%h want 1/4/bb", bus.rf_we, bus.rf_a3, bus.rf_wd); end
    tick();
    set_pipe(0, 0, 0, 0);
    #1;
    n_vec++; if (bus.rf_we !== 1'b0 || bus.buf_count !== 2'd1) begin n_err++; $display("FAIL kill_suppress got we=%b cnt=%0d want 0/1", bus.rf_we, bus.buf_count); end
    tick();
    n_vec++; if (bus.rf_we !== 1'b0 || bus.buf_count !== 2'd0) begin n_err++; $display("FAIL kill_popped got we=%b cnt=%0d want 0/0", bus.rf_we, bus.buf_count); end
    set_pipe(1, 1, 5'd4, 32'hCC);
    set_lu(1, 5'd4, 32'hAA);
    tick();
    set_lu(0, 0, 0);
    set_pipe(0, 0, 0, 0);
    #1;
    n_vec++; if ({bus.rf_we, bus.rf_a3, bus.rf_wd} !== {1'b1, 5'd4, 32'hAA}) begin n_err++; $display("FAIL kill_same_cycle got we=%b a3=%0d wd=%h want 1/4/aa", bus.rf_we, bus.rf_a3, bus.rf_wd); end
  endtask

  task automatic test_full_x0;
    do_reset();
    set_pipe(1, 1, 5'd8, 32'h88);
    set_lu(1, 5'd1, 32'h1);
    tick();
    set_lu(1, 5'd2, 32'h2);
    #1;
    n_vec++; if (bus.lu_ready !== 1'b1 || bus.buf_count !== 2'd1) begin n_err++; $display("FAIL full_one got rdy=%b cnt=%0d want 1/1", bus.lu_ready, bus.buf_count); end
    tick();
    set_lu(1, 5'd3, 32'h3);
    #1;
    n_vec++; if (bus.lu_ready !== 1'b0 || bus.buf_count !== 2'd2) begin n_err++; $display("FAIL full_two got rdy=%b cnt=%0d want 0/2", bus.lu_ready, bus.buf_count); end
    tick();
    n_vec++; if (bus.lu_ready !== 1'b0 || bus.buf_count !== 2'd2) begin n_err++; $display("FAIL full_stalled got rdy=%b cnt=%0d want 0/2", bus.lu_ready, bus.buf_count); end
    set_pipe(0, 0, 0, 0);
    #1;
    n_vec++; if (bus.rf_a3 !== 5'd1 || bus.lu_ready !== 1'b0) begin n_err++; $display("FAIL full_pop_push got a3=%0d rdy=%b want 1/0", bus.rf_a3, bus.lu_ready); end
    tick();
    n_vec++; if (bus.buf_count !== 2'd1 || bus.rf_a3 !== 5'd2) begin n_err++; $display("FAIL full_order2 got cnt=%0d a3=%0d want 1/2", bus.buf_count, bus.rf_a3); end
    tick();
    set_lu(0, 0, 0);
    #1;
    n_vec++; if (bus.buf_count !== 2'd1 || bus.rf_a3 !== 5'd3 || bus.rf_wd !== 32'h3) begin n_err++; $display("FAIL full_order3 got cnt=%0d a3=%0d wd=%h want 1/3/3", bus.buf_count, bus.rf_a3, bus.rf_wd); end
    set_pipe(1, 1, 5'd8, 32'h88);
    set_lu(1, 5'd0, 32'h5);
    #1;
    n_vec++; if (bus.lu_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready got %b want 1", bus.lu_ready); end
    tick();
    set_lu(0, 0, 0);
    set_pipe(0, 0, 0, 0);
    #1;
    n_vec++; if (bus.buf_count !== 2'd1 || bus.rf_a3 !== 5'd3) begin n_err++; $display("FAIL x0_not_stored got cnt=%0d a3=%0d want 1/3", bus.buf_count, bus.rf_a3); end
    tick();
    n_vec++; if (bus.buf_count !== 2'd0 || bus.rf_we !== 1'b0) begin n_err++; $display("FAIL x0_empty got cnt=%0d we=%b want 0/0", bus.buf_count, bus.rf_we); end
  endtask

  task automatic test_async_reset;
    do_reset();
    set_pipe(1, 1, 5'd8, 32'h88);
    set_lu(1, 5'd1, 32'h1);
    tick();
    set_lu(1, 5'd2, 32'h2);
    tick();
    set_lu(0, 0, 0);
    for (int k = 0; k < 4; k++) tick();
    n_vec++; if (bus.stall_req !== 1'b1 || bus.buf_count !== 2'd2) begin n_err++; $display("FAIL arst_pre got stall=%b cnt=%0d want 1/2", bus.stall_req, bus.buf_count); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.buf_count !== 2'd0 || bus.stall_req !== 1'b0) begin n_err++; $display("FAIL arst_state got cnt=%0d stall=%b want 0/0", bus.buf_count, bus.stall_req); end
    n_vec++; if (bus.rf_we !== 1'b0 || bus.lu_ready !== 1'b1) begin n_err++; $display("FAIL arst_port got we=%b rdy=%b want 0/1", bus.rf_we, bus.lu_ready); end
    set_pipe(0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++; if (bus.buf_count !== 2'd0 || bus.rf_we !== 1'b0) begin n_err++; $display("FAIL arst_after got cnt=%0d we=%b want 0/0", bus.buf_count, bus.rf_we); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    set_pipe(0, 0, 0, 0);
    set_lu(0, 0, 0);
    test_reset();
    test_pipe_gating();
    test_idle_drain();
    test_priority();
    test_starvation();
    test_kill();
    test_full_x0();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources:
  - the in-order pipeline writeback stream (result, A3, RegW out of the writeback result mux);
  - a long-latency unit (multiply/divide/late load) that returns results out of band.
- The pipeline always has priority. Long-latency results are held in a small FIFO, drained into free write-port cycles, and the block requests a pipeline stall when a result starves.
- Also suppresses stale long-latency writes that a younger pipeline write has overtaken.

Parameters:
- XLEN, 32, data width of results.
- REG_AW, 5, register address width.
- DEPTH, 2, long-latency FIFO entries (>=1).
- STARVE_LIMIT, 4, consecutive non-drained cycles before stall request (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_valid  in  1  pipeline writeback slot holds an instruction.
- pipe_regw  in  1  that instruction writes a register.
- pipe_rd  in  REG_AW  destination register.
- pipe_result  in  XLEN  selected writeback result.
- lu_valid  in  1  long-latency result offered.
- lu_ready  out  1  FIFO can accept (= !full).
- lu_rd  in  REG_AW  long-latency destination.
- lu_data  in  XLEN  long-latency result.
- rf_we  out  1  register-file write enable.
- rf_a3  out  REG_AW  register-file write address.
- rf_wd  out  XLEN  register-file write data.
- stall_req  out  1  request upstream to insert a writeback bubble.
- buf_count  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, all kill bits clear, starve counter 0.
  - Outputs: lu_ready=1, rf_we=0, rf_a3=0, rf_wd=0, stall_req=0, buf_count=0.
- pipe_win = pipe_valid & pipe_regw & (pipe_rd != 0).
- Write port (combinational, same cycle):
  - If pipe_win: rf_we=1, rf_a3=pipe_rd, rf_wd=pipe_result.
  - Else if FIFO non-empty and head not killed: rf_we=1, rf_a3/rf_wd = head; head pops at clock edge.
  - Else: rf_we=0, rf_a3=0, rf_wd=0.
- Killed head pops in any cycle, including cycles where pipe_win=1. It never drives rf_we.
- Enqueue:
  - Handshake is lu_valid & lu_ready at the clock edge.
  - lu_rd==0 is accepted (handshake completes) but not stored.
  - A new entry is written with kill=0.
  - A new entry becomes drainable the cycle after acceptance (no same-cycle bypass).
- Simultaneous pop and push when full: lu_ready stays 0 (computed from registered occupancy). No push that cycle.
- Kill rule:
  - When pipe_win, every resident FIFO entry with rd==pipe_rd gets kill=1 at the clock edge.
  - An entry accepted in that same cycle is not killed.
  - The head being written in that cycle cannot match (the pipeline owns the port).
- Starve counter:
  - Increments each cycle the FIFO holds a non-killed head that does not pop.
  - Resets to 0 on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- stall_req = registered (counter == STARVE_LIMIT).
  - Deasserts the cycle after the head pops.
  - The arbiter keeps pipeline priority while stall_req=1; the bubble comes from upstream.
- Ordering: FIFO order is preserved; writes leave in acceptance order.
- buf_count counts stored entries, including killed ones.
- Reset mid-operation: contents discarded, outputs return to reset values immediately.

Test Plan:
- Idle drain: lu_valid=1, lu_rd=5, lu_data=0xDEAD for 1 cycle, pipe_valid=0 -> next cycle rf_we=1, rf_a3=5, rf_wd=0xDEAD; buf_count 1->0.
- Priority/collision: FIFO head rd=7 with pipe_win rd=3 data=0x11 -> rf_a3=3, rf_wd=0x11, head held, buf_count stays 1; next idle cycle writes rd=7.
- Starvation: FIFO holds rd=9, pipe_win every cycle -> stall_req=1 after STARVE_LIMIT+1 cycles (5). Drop pipe_valid one cycle -> rd=9 written, stall_req=0 next cycle.
- Kill: FIFO holds rd=4 data=0xAA, pipe_win rd=4 data=0xBB -> rf_wd=0xBB. Subsequent cycles: entry pops with rf_we=0, register 4 never gets 0xAA.
- Full/x0: DEPTH=2, push rd=1 and rd=2 under continuous pipe_win -> lu_ready=0, third lu_valid stalls; lu_rd=0 push completes handshake with buf_count unchanged.
- Async reset with buf_count=2, stall_req=1: assert rst_n=0 mid-cycle -> buf_count=0, stall_req=0, rf_we=0, lu_ready=1 without a clock edge.
